// File: rtl/seq_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per clock, 2N-bit product.
// Optional macro MUL_EARLY_EXIT_EN ends the run once the remaining multiplier bits are all zero.
module seq_mul #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] rs1_reg,
  input  logic [N-1:0] rs2_reg,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] mul_rd,
  output logic [N-1:0] mul_rdh,
  output logic         overflow
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [2*N-1:0] mcand_sh;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_next;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           last_step;

  // The multiplicand is kept pre-shifted by the current bit index, so each step is one add.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand_sh : '0);
`ifdef MUL_EARLY_EXIT_EN
    last_step = (cnt == CW'(1)) || (mplier[N-1:1] == '0);
`else
    last_step = (cnt == CW'(1));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mcand_sh <= '0;
      acc      <= '0;
      mplier   <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mul_rd   <= '0;
      mul_rdh  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand_sh <= {{N{1'b0}}, rs1_reg};
            mplier   <= rs2_reg;
            acc      <= '0;
            cnt      <= CW'(N);
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc      <= acc_next;
          mcand_sh <= mcand_sh << 1;
          mplier   <= mplier >> 1;
          cnt      <= cnt - CW'(1);
          // Results are published on the edge entering DONE so they are visible with done.
          if (last_step) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            mul_rd   <= acc_next[N-1:0];
            mul_rdh  <= acc_next[2*N-1:N];
            overflow <= |acc_next[2*N-1:N];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: stimulus pushes expected products, a negedge monitor pops on done.
module tb_seq_mul;

  localparam int N = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] rs1_reg;
  logic [N-1:0] rs2_reg;
  logic         busy;
  logic         done;
  logic [N-1:0] mul_rd;
  logic [N-1:0] mul_rdh;
  logic         overflow;

  seq_mul #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .rs1_reg(rs1_reg), .rs2_reg(rs2_reg),
    .busy(busy), .done(done), .mul_rd(mul_rd), .mul_rdh(mul_rdh), .overflow(overflow)
  );

  typedef struct {
    logic [2*N-1:0] prod;
    int             cyc;
  } exp_t;

  exp_t           sb[$];
  int             cyc = 0;
  int             checks = 0;
  int             errors = 0;
  bit             active = 0;
  int             accept_cyc = 0;
  int             done_cyc = 0;
  logic [2*N-1:0] last_prod = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int latency(input logic [N-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int i = 0; i < N; i++) if (b[i]) h = i;
    return h + 2;
`else
    return N + 1;
`endif
  endfunction

  // Drives a request in the current cycle; the model decides whether the DUT can accept it.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold);
    exp_t e;
    start   = 1'b1;
    rs1_reg = a;
    rs2_reg = b;
    if (!rst && (!active || cyc >= done_cyc)) begin
      e.prod     = (2*N)'(a) * (2*N)'(b);
      e.cyc      = cyc + latency(b);
      sb.push_back(e);
      accept_cyc = cyc;
      done_cyc   = e.cyc;
      active     = 1'b1;
    end
    @(posedge clk) #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) @(posedge clk) #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk) #1;
    rst       = 1'b0;
    sb.delete();
    active    = 1'b0;
    last_prod = '0;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_mul_rd", 64'(mul_rd), 64'd0);
    checkOutput("rst_mul_rdh", 64'(mul_rdh), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
  endtask

  // Monitor: pops on done, otherwise checks that published results hold and busy matches the model.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("busy", 64'(busy), 64'(active && cyc > accept_cyc && cyc < done_cyc));
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        errors++;
        $display("[TB] FAIL timeout: no done by cycle %0d, expected product 0x%0h", sb[0].cyc, sb[0].prod);
        void'(sb.pop_front());
      end
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
          checkOutput("product", {32'd0, mul_rdh, mul_rd}, 64'(e.prod));
          checkOutput("overflow", 64'(overflow), 64'(e.prod[2*N-1:N] != '0));
          last_prod = e.prod;
        end
      end else begin
        checkOutput("hold_product", {32'd0, mul_rdh, mul_rd}, 64'(last_prod));
        checkOutput("hold_overflow", 64'(overflow), 64'(last_prod[2*N-1:N] != '0));
      end
    end
  end

  initial begin
    int c;
    rst     = 1'b1;
    start   = 1'b0;
    rs1_reg = '0;
    rs2_reg = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("init_busy", 64'(busy), 64'd0);
    checkOutput("init_done", 64'(done), 64'd0);
    checkOutput("init_product", {32'd0, mul_rdh, mul_rd}, 64'd0);
    checkOutput("init_overflow", 64'(overflow), 64'd0);

    applyStimulus(16'd123, 16'd456, 1'b0);
    waitUntil(done_cyc + 2);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
    waitUntil(done_cyc + 1);

    // Back-to-back with start held through the whole first run.
    applyStimulus(16'd3, 16'd5, 1'b1);
    waitUntil(done_cyc);
    applyStimulus(16'h1000, 16'h0010, 1'b0);
    waitUntil(done_cyc + 1);

    // A start pulse and operand changes mid-run must be ignored.
    applyStimulus(16'd1000, 16'h4321, 1'b0);
    repeat (3) @(posedge clk) #1;
    applyStimulus(16'd99, 16'd77, 1'b0);
    rs1_reg = 16'hAAAA;
    rs2_reg = 16'h5555;
    waitUntil(done_cyc + 1);

    // Reset in cycle 8 of a run aborts it, then a fresh request must work.
    c = cyc;
    applyStimulus(16'h1234, 16'h5678, 1'b0);
    waitUntil(c + 8);
    doReset();
    repeat (20) @(posedge clk) #1;
    applyStimulus(16'h00FF, 16'h0101, 1'b0);
    waitUntil(done_cyc + 1);

    applyStimulus(16'd7, 16'd1, 1'b0);
    waitUntil(done_cyc + 1);
    applyStimulus(16'd2, 16'h8000, 1'b0);
    waitUntil(done_cyc + 1);
    applyStimulus(16'd9, 16'd0, 1'b0);
    waitUntil(done_cyc + 1);

    for (int i = 0; i < 20; i++) begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      a = N'($urandom);
      b = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
      if ($urandom_range(0, 1) == 1) waitUntil(done_cyc);
      else waitUntil(done_cyc + 1 + int'($urandom_range(0, 2)));
      applyStimulus(a, b, 1'b0);
    end

    c = 0;
    while (sb.size() > 0 && c < 100) begin
      @(posedge clk) #1;
      c++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    repeat (3) @(posedge clk) #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
